// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : RV32M multiply/divide controller. Runs an iterative shift-add
//             multiplier and a restoring divider one operation at a time,
//             stalls the pipeline until the result is ready, then pulses done
//             for one cycle with the 32-bit result.
//  Options  : MULDIV_FAST_MUL_EN - multiplies use one combinational 33x33
//             signed product (IDLE -> FIX -> DONE); divides stay iterative.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN-1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;     // final result must be negated in FIX
  logic [XLEN-1:0]   opd_q;     // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0]   hi_q;      // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;      // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0]   res_q;

  // Operand decode in IDLE: which operands are signed and their magnitudes
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, special, accept, neg_in;
  logic [XLEN-1:0] a_abs, b_abs, res_special;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
  assign b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg    = a_signed & op_a[XLEN-1];
  assign b_neg    = b_signed & op_b[XLEN-1];
  assign a_abs    = a_neg ? -op_a : op_a;
  assign b_abs    = b_neg ? -op_b : op_b;
  // Remainder follows the dividend; quotient and products follow sign(a)^sign(b)
  assign neg_in   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
  assign special  = div_zero | div_ovf;
  assign accept   = (state_q == IDLE) && start && !flush;
  assign res_special = div_zero ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0   : INT_MIN);

  // One iteration of each algorithm, evaluated from the working registers
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  assign div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opd_q};
  assign prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix   = neg_q ? -lo_q : lo_q;
  assign rem_fix   = neg_q ? -hi_q : hi_q;
  assign fix_val   = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                     : prod_fix[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended operands give the exact signed/unsigned product in 2*XLEN bits
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{a_neg}}, op_a};
  assign fast_b    = {{XLEN{b_neg}}, op_b};
  assign fast_prod = fast_a * fast_b;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    result  = (state_q == DONE) ? res_q : '0;
    stall   = start && (state_q != DONE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (special) state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) state_d = FIX;
`endif
          else state_d = CALC;
        end
      end
      CALC: begin
        if (flush)                   state_d = IDLE;
        else if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX:     state_d = flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign fix-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      opd_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= funct3;
            neg_q <= neg_in;
            cnt_q <= '0;
            hi_q  <= '0;
            opd_q <= is_div ? b_abs : a_abs;
            lo_q  <= is_div ? a_abs : b_abs;
            if (special) res_q <= res_special;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
              neg_q <= 1'b0;
              hi_q  <= fast_prod[2*XLEN-1:XLEN];
              lo_q  <= fast_prod[XLEN-1:0];
            end
`endif
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (!op_q[2]) begin
            {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
          end else if (!div_trial[XLEN]) begin
            hi_q <= div_trial[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
        end
        FIX:     res_q <= fix_val;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer: directed vector table,
//             randomized operations against a plain-arithmetic model, and
//             hand sequences for flush and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk, rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs [13];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference results from RV32M arithmetic rules
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub_s;
    logic [63:0] p;
    logic [31:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub_s = longint'({32'b0, b});
    r    = '0;
    case (f)
      3'b000: begin p = sa * sb;                  r = p[31:0];  end
      3'b001: begin p = sa * sb;                  r = p[63:32]; end
      3'b010: begin p = sa * ub_s;                r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b};  r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return $urandom_range(0, 50);
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation with start held until done; operands are scrambled
  // after acceptance to confirm they were latched.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string tag);
    int          cyc;
    bit          seen;
    bit          hs_ok;
    logic [31:0] got;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    cyc = 0; seen = 0; hs_ok = 1; got = '0;
    while (!seen && cyc <= 100) begin
      #1;
      if (done) begin
        seen = 1;
        got  = result;
        if (stall !== 1'b0 || busy !== 1'b1) hs_ok = 0;
        start = 1'b0;
      end else begin
        if (stall !== 1'b1 || result !== 32'h0 || busy !== (cyc > 0)) hs_ok = 0;
        @(negedge clk);
        cyc++;
        op_a = $urandom; op_b = $urandom;
      end
    end
    if (!seen) begin
      check_eq($sformatf("%s.timeout", tag), 32'd0, 32'd1);
      start = 1'b0;
    end else begin
      check_eq($sformatf("%s.result", tag), got, exp_res);
      check_eq($sformatf("%s.latency", tag), 32'(cyc), 32'(exp_lat(f, a, b)));
      check_eq($sformatf("%s.handshake", tag), {31'b0, hs_ok}, 32'd1);
      @(negedge clk); #1;
      check_eq($sformatf("%s.idle_after", tag), {30'b0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    bit          saw_done;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{3'b111, 32'd5,        32'd0,        32'd5};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{3'b111, 32'hFFFFFFF1, 32'd16,       32'd1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #3;
    check_eq("reset.outputs", {29'b0, busy, done, stall}, 32'd0);
    check_eq("reset.result", result, 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp_res, $sformatf("vec%0d", i));

    // Flush in IDLE blocks acceptance
    @(negedge clk); start = 1'b1; flush = 1'b1; funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5;
    repeat (3) @(negedge clk);
    #1 check_eq("flush_idle.busy", {31'b0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // Flush mid-divide aborts without a done pulse
    @(negedge clk); start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    #1 check_eq("flush_calc.busy", {31'b0, busy}, 32'd0);
    saw_done = 0;
    repeat (40) begin @(negedge clk); #1 if (done) saw_done = 1; end
    check_eq("flush_calc.no_done", {31'b0, saw_done}, 32'd0);
    run_op(3'b101, 32'd9, 32'd3, 32'd3, "after_flush");

    // Asynchronous reset mid-CALC
    @(negedge clk); start = 1'b1; funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_eq("areset_calc.outputs", {30'b0, busy, done}, 32'd0);
    check_eq("areset_calc.result", result, 32'h0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_op(3'b000, 32'd6, 32'd7, 32'd42, "after_reset");

    // Asynchronous reset during the DONE cycle drops the result at once
    @(negedge clk); start = 1'b1; funct3 = 3'b100; op_a = 32'd5; op_b = 32'd0;
    @(negedge clk); #1;
    check_eq("areset_done.pre_result", result, 32'hFFFFFFFF);
    #1 rst = 1'b1;
    #1 check_eq("areset_done.result", result, 32'h0);
    check_eq("areset_done.done", {31'b0, done}, 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op(rf, ra, rb, ref_model(rf, ra, rb), $sformatf("rand%0d_f%0d", i, rf));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
